// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the EX-stage controller and
// seq_alu.
//   start_i  : request strobe, taken only while busy_o is low
//   ctrl_i   : 4-bit opcode
//   src1_i   : operand A
//   src2_i   : operand B
//   shamt_i  : immediate shift amount
//   result_o : primary result (low product / quotient)
//   hi_o     : high product / remainder, 0 for other ops
//   zero_o   : result_o == 0
//   busy_o   : multi-cycle op in progress
//   done_o   : one-cycle pulse, outputs newly valid
// master = controller side, slave = ALU side.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [SHW-1:0]   shamt_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  result_o, hi_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
    output result_o, hi_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU for the EX stage. Single-cycle ops complete on the
// edge that accepts them; MULU (shift-add) and DIVU (restoring) iterate one
// bit per edge for WIDTH edges.
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : seq_alu_if slave modport (request operands in, results out)
// WIDTH must be even and >= 8; SHW must equal log2(WIDTH).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  seq_alu_if.slave   bus
);
  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = SHW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg;   // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo_reg;   // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opb_reg;      // multiplicand / divisor
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             done_reg;

  // Request decode
  logic accept, is_mulu, is_divu, div_by_zero, last_iter;
  assign accept      = bus.start_i && (state_reg == IDLE);
  assign is_mulu     = (bus.ctrl_i == 4'd13);
  assign is_divu     = (bus.ctrl_i == 4'd14);
  assign div_by_zero = is_divu && (bus.src2_i == '0);
  assign last_iter   = (cnt_reg == CNT_W'(1));

  // Bitwise ops, one cell per bit
  logic [WIDTH-1:0] and_res, or_res, xnor_res;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_res[gi]  = bus.src1_i[gi] & bus.src2_i[gi];
    assign or_res[gi]   = bus.src1_i[gi] | bus.src2_i[gi];
    assign xnor_res[gi] = ~(bus.src1_i[gi] ^ bus.src2_i[gi]);
  end

  // Register-sourced shift amount uses only the low SHW bits of src1.
  logic [SHW-1:0]   sh_var;
  logic [WIDTH-1:0] sc_result;
  assign sh_var = bus.src1_i[SHW-1:0];

  always_comb begin
    sc_result = '0;
    case (bus.ctrl_i)
      4'd0:  sc_result = and_res;
      4'd1:  sc_result = or_res;
      4'd2:  sc_result = bus.src1_i + bus.src2_i;
      4'd3:  sc_result = bus.src1_i - bus.src2_i;
      4'd4:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      4'd5:  sc_result = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      4'd6:  sc_result = xnor_res;
      4'd7:  sc_result = bus.src2_i << bus.shamt_i;
      4'd8:  sc_result = bus.src2_i << sh_var;
      4'd9:  sc_result = {bus.src2_i[HALF-1:0], {HALF{1'b0}}};
      4'd10: sc_result = bus.src1_i | {{HALF{1'b0}}, bus.src2_i[HALF-1:0]};
      4'd11: sc_result = bus.src2_i >> sh_var;
      4'd12: sc_result = $unsigned($signed(bus.src2_i) >>> sh_var);
      default: sc_result = '0;  // 13/14 go multi-cycle, 15 is reserved
    endcase
  end

  // One shift-add step: add multiplicand if multiplier LSB set, then shift
  // the 2*WIDTH+1 bit {carry, hi, lo} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  assign mul_sum     = {1'b0, acc_hi_reg} + {1'b0, (acc_lo_reg[0] ? opb_reg : '0)};
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

  // One restoring-divide step: shift next dividend bit into the remainder,
  // keep the difference only when it does not borrow.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_next, div_quo_next;
  assign div_shift    = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, opb_reg};
  assign div_ok       = ~div_diff[WIDTH];
  assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_next = {acc_lo_reg[WIDTH-2:0], div_ok};

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mulu)                     state_next = MUL;
        else if (accept && is_divu && !div_by_zero) state_next = DIV;
      end
      MUL, DIV: if (last_iter) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy_o   = (state_reg != IDLE);
    bus.done_o   = done_reg;
    bus.result_o = result_reg;
    bus.hi_o     = hi_reg;
    bus.zero_o   = (result_reg == '0);
  end

  // Datapath. Result registers change only when an op completes, so they
  // hold through a multi-cycle op and past any ignored start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg    <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      hi_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_mulu || (is_divu && !div_by_zero)) begin
              acc_hi_reg <= '0;
              acc_lo_reg <= bus.src1_i;
              opb_reg    <= bus.src2_i;
              cnt_reg    <= CNT_W'(WIDTH);
            end else if (div_by_zero) begin
              result_reg <= '1;
              hi_reg     <= bus.src1_i;
              done_reg   <= 1'b1;
            end else begin
              result_reg <= sc_result;
              hi_reg     <= '0;
              done_reg   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi_reg <= mul_hi_next;
          acc_lo_reg <= mul_lo_next;
          cnt_reg    <= cnt_reg - CNT_W'(1);
          if (last_iter) begin
            hi_reg     <= mul_hi_next;
            result_reg <= mul_lo_next;
            done_reg   <= 1'b1;
          end
        end
        DIV: begin
          acc_hi_reg <= div_rem_next;
          acc_lo_reg <= div_quo_next;
          cnt_reg    <= cnt_reg - CNT_W'(1);
          if (last_iter) begin
            hi_reg     <= div_rem_next;
            result_reg <= div_quo_next;
            done_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: a 32-bit instance gets a vector table of
// single-cycle ops plus hand-written multi-cycle sequences; a 16-bit
// instance repeats the key cases at the smaller width.
module tb_seq_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst16;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.WIDTH(32), .SHW(5)) bus();
  seq_alu_if #(.WIDTH(16), .SHW(4)) bus16();

  seq_alu #(.WIDTH(32), .SHW(5)) dut   (.clk_i(clk), .rst_i(rst),   .bus(bus));
  seq_alu #(.WIDTH(16), .SHW(4)) dut16 (.clk_i(clk), .rst_i(rst16), .bus(bus16));

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.start_i   = 1'b0;
    bus16.start_i = 1'b0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.shamt_i = s;
    bus.start_i = 1'b1;
  endtask

  task automatic drive16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    bus16.ctrl_i  = c;
    bus16.src1_i  = a;
    bus16.src2_i  = b;
    bus16.shamt_i = '0;
    bus16.start_i = 1'b1;
  endtask

  // Issue a MULU/DIVU and expect done exactly 32 edges after acceptance.
  // inject_at > 0 pulses an ADD request while busy at that edge.
  task automatic run_mc(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [31:0] exp_hi, input int inject_at);
    int bad = 0;
    drive(c, a, b, 5'd0);
    step();
    chk({nm, "_busy_e0"}, 64'(bus.busy_o), 64'(1));
    chk({nm, "_done_e0"}, 64'(bus.done_o), 64'(0));
    for (int k = 1; k <= 32; k++) begin
      if (k == inject_at) drive(4'd2, 32'h1111_1111, 32'h2222_2222, 5'd3);
      step();
      if (k < 32 && (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0)) bad++;
    end
    chk({nm, "_busy_window"}, 64'(bad), 64'(0));
    chk({nm, "_done"},   64'(bus.done_o),   64'(1));
    chk({nm, "_busy"},   64'(bus.busy_o),   64'(0));
    chk({nm, "_result"}, 64'(bus.result_o), 64'(exp_res));
    chk({nm, "_hi"},     64'(bus.hi_o),     64'(exp_hi));
    chk({nm, "_zero"},   64'(bus.zero_o),   64'(exp_res == 32'h0));
    $display("txn %s a=%h b=%h result=%h hi=%h", nm, a, b, bus.result_o, bus.hi_o);
  endtask

  task automatic run_mc16(input string nm, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic [15:0] exp_hi);
    int bad = 0;
    drive16(c, a, b);
    step();
    for (int k = 1; k <= 16; k++) begin
      if (bus16.busy_o !== 1'b1 || bus16.done_o !== 1'b0) bad++;
      step();
    end
    chk({nm, "_busy_window"}, 64'(bad), 64'(0));
    chk({nm, "_done"},   64'(bus16.done_o),   64'(1));
    chk({nm, "_result"}, 64'(bus16.result_o), 64'(exp_res));
    chk({nm, "_hi"},     64'(bus16.hi_o),     64'(exp_hi));
    $display("txn %s a=%h b=%h result=%h hi=%h", nm, a, b, bus16.result_o, bus16.hi_o);
  endtask

  task automatic sc16(input string nm, input logic [3:0] c, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] exp_res);
    drive16(c, a, b);
    step();
    chk({nm, "_result"}, 64'(bus16.result_o), 64'(exp_res));
    chk({nm, "_done"},   64'(bus16.done_o),   64'(1));
    $display("txn %s a=%h b=%h result=%h", nm, a, b, bus16.result_o);
  endtask

  initial begin
    int bad;

    vecs[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 32'h0, 1'b0};
    vecs[1]  = '{4'd3,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 32'h0, 1'b1};
    vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 32'h0, 1'b0};
    vecs[3]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 32'h0, 1'b1};
    vecs[4]  = '{4'd12, 32'h0000_0004, 32'h8000_0000, 5'd0,  32'hF800_0000, 32'h0, 1'b0};
    vecs[5]  = '{4'd9,  32'h0000_0000, 32'h0000_1234, 5'd0,  32'h1234_0000, 32'h0, 1'b0};
    vecs[6]  = '{4'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 32'h0, 1'b0};
    vecs[7]  = '{4'd1,  32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 32'h0, 1'b0};
    vecs[8]  = '{4'd6,  32'hFFFF_0000, 32'hFF00_FF00, 5'd0,  32'hFF00_00FF, 32'h0, 1'b0};
    vecs[9]  = '{4'd7,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 32'h0, 1'b0};
    vecs[10] = '{4'd8,  32'hFFFF_FFE4, 32'h0000_0003, 5'd0,  32'h0000_0030, 32'h0, 1'b0};
    vecs[11] = '{4'd10, 32'h1234_0000, 32'hFFFF_5678, 5'd0,  32'h1234_5678, 32'h0, 1'b0};
    vecs[12] = '{4'd11, 32'h0000_0024, 32'h8000_0000, 5'd0,  32'h0800_0000, 32'h0, 1'b0};
    vecs[13] = '{4'd15, 32'h0000_0005, 32'h0000_0006, 5'd0,  32'h0000_0000, 32'h0, 1'b1};
    vecs[14] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  32'h0000_0001, 32'h0, 1'b0};
    vecs[15] = '{4'd3,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 32'h0, 1'b0};

    rst   = 1'b1;
    rst16 = 1'b1;
    bus.start_i = 1'b0; bus.ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0; bus.shamt_i = '0;
    bus16.start_i = 1'b0; bus16.ctrl_i = '0; bus16.src1_i = '0; bus16.src2_i = '0;
    bus16.shamt_i = '0;
    step();
    step();
    chk("rst_result", 64'(bus.result_o), 64'(0));
    chk("rst_hi",     64'(bus.hi_o),     64'(0));
    chk("rst_zero",   64'(bus.zero_o),   64'(1));
    chk("rst_busy",   64'(bus.busy_o),   64'(0));
    chk("rst_done",   64'(bus.done_o),   64'(0));
    chk("rst16_zero", 64'(bus16.zero_o), 64'(1));
    chk("rst16_done", 64'(bus16.done_o), 64'(0));
    rst   = 1'b0;
    rst16 = 1'b0;

    // Single-cycle table
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh);
      step();
      chk($sformatf("vec%0d_result", i), 64'(bus.result_o), 64'(vecs[i].res));
      chk($sformatf("vec%0d_hi", i),     64'(bus.hi_o),     64'(vecs[i].hi));
      chk($sformatf("vec%0d_zero", i),   64'(bus.zero_o),   64'(vecs[i].zero));
      chk($sformatf("vec%0d_done", i),   64'(bus.done_o),   64'(1));
      chk($sformatf("vec%0d_busy", i),   64'(bus.busy_o),   64'(0));
      $display("txn vec%0d ctrl=%0d a=%h b=%h result=%h", i, vecs[i].ctrl, vecs[i].a,
               vecs[i].b, bus.result_o);
    end
    step();
    chk("idle_done_drop",   64'(bus.done_o),   64'(0));
    chk("idle_result_hold", 64'(bus.result_o), 64'(32'hFFFF_FFFF));

    // Multi-cycle
    run_mc("mulu_max",   4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_mc("divu_100_7", 4'd14, 32'd100,       32'd7,         32'd14,        32'd2,         0);
    run_mc("mulu_inj",   4'd13, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 32'h0000_0012, 5);
    // Back-to-back: second request issued in the first one's done cycle.
    run_mc("mulu_b2b_a", 4'd13, 32'd3,         32'd5,         32'd15,        32'd0,         0);
    run_mc("mulu_b2b_b", 4'd13, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 0);
    run_mc("divu_big",   4'd14, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 0);

    // Divide by zero completes immediately without going busy.
    drive(4'd14, 32'd9, 32'd0, 5'd0);
    step();
    chk("div0_result", 64'(bus.result_o), 64'(32'hFFFF_FFFF));
    chk("div0_hi",     64'(bus.hi_o),     64'(9));
    chk("div0_done",   64'(bus.done_o),   64'(1));
    chk("div0_busy",   64'(bus.busy_o),   64'(0));
    step();
    chk("div0_busy_after", 64'(bus.busy_o), 64'(0));
    chk("div0_done_after", 64'(bus.done_o), 64'(0));
    $display("txn div0 result=%h hi=%h", bus.result_o, bus.hi_o);

    // Reset aborts an in-flight DIVU with no done pulse.
    drive(4'd14, 32'd100, 32'd7, 5'd0);
    step();
    chk("abort_busy", 64'(bus.busy_o), 64'(1));
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_result", 64'(bus.result_o), 64'(0));
    chk("abort_hi",     64'(bus.hi_o),     64'(0));
    chk("abort_zero",   64'(bus.zero_o),   64'(1));
    chk("abort_busy0",  64'(bus.busy_o),   64'(0));
    chk("abort_done",   64'(bus.done_o),   64'(0));
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
    end
    chk("abort_quiet", 64'(bad), 64'(0));
    $display("txn abort_divu result=%h", bus.result_o);

    // 16-bit instance
    sc16("w16_sra",  4'd12, 16'h0004, 16'h8000, 16'hF800);
    sc16("w16_lui",  4'd9,  16'h0000, 16'hAB12, 16'h1200);
    sc16("w16_add",  4'd2,  16'hFFFF, 16'h0001, 16'h0000);
    chk("w16_add_zero", 64'(bus16.zero_o), 64'(1));
    sc16("w16_sllv", 4'd8,  16'hFFF3, 16'h0001, 16'h0008);
    run_mc16("w16_mulu", 4'd13, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
    run_mc16("w16_divu", 4'd14, 16'd100,  16'd7,    16'd14,   16'd2);
    sc16("w16_div0", 4'd14, 16'd5,    16'd0,    16'hFFFF);
    chk("w16_div0_hi",   64'(bus16.hi_o),   64'(5));
    chk("w16_div0_busy", 64'(bus16.busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
